// File: rtl/mont_exp_ctrl.sv
// Host-side controller for the montgomery_exp engine: assembles operands from a
// word stream, starts the engine, and streams the captured result back out.
module mont_exp_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 1024,
    parameter int unsigned EXP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              eng_start,
    output logic [OP_W-1:0]   eng_msg,
    output logic [EXP_W-1:0]  eng_exp,
    output logic [OP_W-1:0]   eng_n,
    output logic [OP_W-1:0]   eng_rmodn,
    output logic [OP_W-1:0]   eng_r2modn,
    input  logic [OP_W-1:0]   eng_result,
    input  logic              eng_done
);
    localparam int unsigned NW = OP_W / DATA_W;
    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op_sel;
    logic [OP_W-1:0]   r_msg;
    logic [OP_W-1:0]   r_n;
    logic [OP_W-1:0]   r_rmodn;
    logic [OP_W-1:0]   r_r2modn;
    logic [EXP_W-1:0]  r_exp;
    logic [OP_W-1:0]   r_result;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_cnt_last;
    logic              w_exp_word;

    always_comb begin
        w_in_fire    = in_valid && (r_state == ST_LOAD);
        w_out_fire   = out_ready && (r_state == ST_UNLOAD);
        w_cnt_last   = (r_cnt == LAST_WORD);
        w_exp_word   = (r_op_sel == 3'd4);
        w_next_state = r_state;
        in_ready     = 1'b0;
        eng_start    = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_in_fire && w_exp_word) w_next_state = ST_START;
            end
            ST_START: begin
                eng_start    = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) w_next_state = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = w_cnt_last;
                if (w_out_fire && w_cnt_last) w_next_state = ST_LOAD;
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_LOAD;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op_sel <= '0;
            r_msg    <= '0;
            r_n      <= '0;
            r_rmodn  <= '0;
            r_r2modn <= '0;
            r_exp    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        // Words arrive LS first, so each one enters at the top and shifts down.
                        case (r_op_sel)
                            3'd0:    r_msg    <= {in_data, r_msg[OP_W-1:DATA_W]};
                            3'd1:    r_n      <= {in_data, r_n[OP_W-1:DATA_W]};
                            3'd2:    r_rmodn  <= {in_data, r_rmodn[OP_W-1:DATA_W]};
                            3'd3:    r_r2modn <= {in_data, r_r2modn[OP_W-1:DATA_W]};
                            3'd4:    r_exp    <= in_data[EXP_W-1:0];
                            default: ;
                        endcase
                        if (w_exp_word) begin
                            r_op_sel <= '0;
                            r_cnt    <= '0;
                        end else if (w_cnt_last) begin
                            r_op_sel <= r_op_sel + 3'd1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_result <= eng_result;
                        r_cnt    <= '0;
                    end
                end
                ST_UNLOAD: begin
                    if (w_out_fire) begin
                        r_result <= r_result >> DATA_W;
                        r_cnt    <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data   = r_result[DATA_W-1:0];
    assign eng_msg    = r_msg;
    assign eng_n      = r_n;
    assign eng_rmodn  = r_rmodn;
    assign eng_r2modn = r_r2modn;
    assign eng_exp    = r_exp;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a stub engine driving eng_done/eng_result.
module tb_mont_exp_ctrl;
    localparam int DW = 32;
    localparam int OW = 1024;
    localparam int EW = 16;
    localparam int NW = OW / DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          eng_start;
    logic [OW-1:0] eng_msg;
    logic [EW-1:0] eng_exp;
    logic [OW-1:0] eng_n;
    logic [OW-1:0] eng_rmodn;
    logic [OW-1:0] eng_r2modn;
    logic [OW-1:0] eng_result;
    logic          eng_done;

    int n_checks = 0;
    int n_pass   = 0;
    int start_pulses = 0;
    int cyc = 0;

    int            stub_delay = 7;
    int            stub_hold  = 1;
    logic [OW-1:0] stub_result = '0;
    int            stub_cnt;
    logic          stub_armed;

    mont_exp_ctrl #(.DATA_W(DW), .OP_W(OW), .EXP_W(EW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .eng_start(eng_start),
        .eng_msg(eng_msg), .eng_exp(eng_exp), .eng_n(eng_n),
        .eng_rmodn(eng_rmodn), .eng_r2modn(eng_r2modn),
        .eng_result(eng_result), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (eng_start) start_pulses <= start_pulses + 1;
    end

    // Result is only valid on the first done cycle; garbage elsewhere exposes a mistimed capture.
    always @(posedge clk) begin
        if (reset) begin
            stub_armed <= 1'b0;
            stub_cnt   <= 0;
            eng_done   <= 1'b0;
            eng_result <= '1;
        end else if (eng_start) begin
            stub_armed <= 1'b1;
            stub_cnt   <= 1;
            eng_done   <= 1'b0;
            eng_result <= '1;
        end else if (stub_armed) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == stub_delay) begin
                eng_done   <= 1'b1;
                eng_result <= stub_result;
            end else begin
                eng_result <= ~stub_result;
            end
            if (stub_cnt == stub_delay + stub_hold) begin
                eng_done   <= 1'b0;
                stub_armed <= 1'b0;
            end
        end
    end

    function automatic logic [OW-1:0] build_op(input logic [31:0] base, input logic [31:0] step);
        logic [OW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*DW +: DW] = base + step * i;
        return v;
    endfunction

    task automatic send_word(input logic [DW-1:0] d, input int max_gap, output bit ok);
        int n;
        ok = 1'b1;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic load_job(input logic [OW-1:0] m, input logic [OW-1:0] nn,
                            input logic [OW-1:0] rm, input logic [OW-1:0] r2,
                            input logic [DW-1:0] e, input int max_gap, output bit ok);
        logic [OW-1:0] ops [4];
        bit w_ok;
        ops[0] = m; ops[1] = nn; ops[2] = rm; ops[3] = r2;
        ok = 1'b1;
        for (int o = 0; o < 4; o++)
            for (int i = 0; i < NW; i++) begin
                send_word(ops[o][i*DW +: DW], max_gap, w_ok);
                if (!w_ok) begin ok = 1'b0; return; end
            end
        send_word(e, max_gap, w_ok);
        if (!w_ok) ok = 1'b0;
    endtask

    task automatic recv_job(output logic [OW-1:0] res, output logic [NW-1:0] lasts, output bit ok);
        int n;
        ok = 1'b1;
        res = '0;
        lasts = '0;
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            n = 0;
            while (!out_valid && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) begin ok = 1'b0; out_ready = 1'b0; return; end
            res[k*DW +: DW] = out_data;
            lasts[k] = out_last;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (eng_start !== 1'b0) $display("FAIL reset_eng_start: got %b want 0", eng_start); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
    endtask

    task automatic test_load();
        bit ok;
        int base;
        stub_delay  = 7;
        stub_hold   = 1;
        stub_result = build_op(32'd1, 32'd1);
        base = start_pulses;
        load_job(OW'(1), OW'(2), OW'(3), OW'(4), 32'hABCDB5DF, 0, ok);
        n_checks++; if (!ok) $display("FAIL load_timeout: in_ready never high"); else n_pass++;
        @(negedge clk);
        n_checks++; if (eng_start !== 1'b1) $display("FAIL load_start_pulse: got %b want 1", eng_start); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL load_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (eng_exp !== 16'hB5DF) $display("FAIL load_exp: got %h want b5df", eng_exp); else n_pass++;
        n_checks++; if (eng_msg !== OW'(1)) $display("FAIL load_msg: got %h want 1", eng_msg); else n_pass++;
        n_checks++; if (eng_n !== OW'(2)) $display("FAIL load_n: got %h want 2", eng_n); else n_pass++;
        n_checks++; if (eng_rmodn !== OW'(3)) $display("FAIL load_rmodn: got %h want 3", eng_rmodn); else n_pass++;
        n_checks++; if (eng_r2modn !== OW'(4)) $display("FAIL load_r2modn: got %h want 4", eng_r2modn); else n_pass++;
        @(negedge clk);
        n_checks++; if (eng_start !== 1'b0) $display("FAIL load_start_width: got %b want 0", eng_start); else n_pass++;
        n_checks++; if (start_pulses - base !== 1) $display("FAIL load_start_count: got %0d want 1", start_pulses - base); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL load_busy_wait: got %b want 1", busy); else n_pass++;
    endtask

    task automatic test_unload();
        logic [OW-1:0] res;
        logic [NW-1:0] lasts;
        bit ok;
        int n = 0;
        while (!eng_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (eng_done !== 1'b1) $display("FAIL unload_done_timeout: eng_done never seen"); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL unload_early_valid: got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL unload_latency: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'd1) $display("FAIL unload_first_word: got %h want 1", out_data); else n_pass++;
        recv_job(res, lasts, ok);
        n_checks++; if (!ok) $display("FAIL unload_timeout: out_valid dropped"); else n_pass++;
        n_checks++; if (res !== build_op(32'd1, 32'd1)) $display("FAIL unload_data: got %h want %h", res, build_op(32'd1, 32'd1)); else n_pass++;
        n_checks++; if (lasts !== {1'b1, {(NW-1){1'b0}}}) $display("FAIL unload_last: got %h want 80000000", lasts); else n_pass++;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL unload_in_ready_after: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL unload_valid_after: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL unload_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_stall();
        logic [OW-1:0] m, nn, rm, r2, exp_res, res;
        logic [DW-1:0] prev_data;
        logic          prev_last, prev_stall, rdy;
        bit ok;
        int base, got, n;
        m  = build_op(32'h1000_0000, 32'd1);
        nn = build_op(32'h2000_0000, 32'd5);
        rm = build_op(32'h3000_0000, 32'd9);
        r2 = build_op(32'h4000_0000, 32'd13);
        exp_res = build_op(32'hC0DE_0000, 32'h0001_0001);
        stub_delay  = 5;
        stub_hold   = 3;
        stub_result = exp_res;
        base = start_pulses;
        load_job(m, nn, rm, r2, 32'hFFFF_1234, 2, ok);
        n_checks++; if (!ok) $display("FAIL stall_load_timeout: in_ready never high"); else n_pass++;
        @(negedge clk);
        n_checks++; if ({eng_msg, eng_n, eng_rmodn, eng_r2modn} !== {m, nn, rm, r2}) $display("FAIL stall_operands: msg %h want %h", eng_msg, m); else n_pass++;
        n_checks++; if (eng_exp !== 16'h1234) $display("FAIL stall_exp: got %h want 1234", eng_exp); else n_pass++;
        res = '0;
        got = 0;
        n = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while (got < NW && n < 2000) begin
            rdy = ($urandom_range(0, 99) >= 35);
            out_ready = rdy;
            if (prev_stall) begin
                n_checks++;
                if (!out_valid || out_data !== prev_data || out_last !== prev_last)
                    $display("FAIL stall_stable: got %h/%b want %h/%b", out_data, out_last, prev_data, prev_last);
                else n_pass++;
            end
            prev_stall = out_valid && !rdy;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && rdy) begin
                res[got*DW +: DW] = out_data;
                n_checks++;
                if (out_last !== (got == NW - 1)) $display("FAIL stall_last_word%0d: got %b want %b", got, out_last, got == NW - 1); else n_pass++;
                got++;
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        n_checks++; if (got != NW) $display("FAIL stall_timeout: got %0d words want %0d", got, NW); else n_pass++;
        n_checks++; if (res !== exp_res) $display("FAIL stall_data: got %h want %h", res, exp_res); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_recapture: out_valid %b in_ready %b want 0/1", out_valid, in_ready); else n_pass++;
        n_checks++; if (start_pulses - base !== 1) $display("FAIL stall_start_count: got %0d want 1", start_pulses - base); else n_pass++;
    endtask

    task automatic test_abort();
        logic [OW-1:0] m, nn, rm, r2, exp_res, res;
        logic [NW-1:0] lasts;
        bit ok;
        int base;
        base = start_pulses;
        for (int i = 0; i < 40; i++) begin
            send_word(32'hDEAD_0000 + i, 0, ok);
        end
        do_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL abort_ctrl: in_ready %b busy %b out_valid %b want 1/0/0", in_ready, busy, out_valid); else n_pass++;
        n_checks++; if (eng_msg !== '0 || eng_n !== '0 || eng_exp !== '0) $display("FAIL abort_regs_cleared: msg %h n %h", eng_msg, eng_n); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (start_pulses != base) $display("FAIL abort_no_start: got %0d pulses want 0", start_pulses - base); else n_pass++;
        m  = build_op(32'd7, 32'd3);
        nn = build_op(32'h0BAD_F00D, 32'd1);
        rm = build_op(32'h7777_0000, 32'd2);
        r2 = build_op(32'h8888_0000, 32'd4);
        exp_res = build_op(32'h5A5A_0000, 32'd3);
        stub_delay  = 4;
        stub_hold   = 1;
        stub_result = exp_res;
        load_job(m, nn, rm, r2, 32'h0000_0011, 0, ok);
        @(negedge clk);
        n_checks++; if ({eng_msg, eng_n, eng_rmodn, eng_r2modn} !== {m, nn, rm, r2}) $display("FAIL abort_clean_operands: msg %h want %h", eng_msg, m); else n_pass++;
        n_checks++; if (eng_exp !== 16'h0011) $display("FAIL abort_clean_exp: got %h want 0011", eng_exp); else n_pass++;
        recv_job(res, lasts, ok);
        n_checks++; if (!ok || res !== exp_res) $display("FAIL abort_clean_result: got %h want %h", res, exp_res); else n_pass++;
        n_checks++; if (start_pulses - base !== 1) $display("FAIL abort_start_count: got %0d want 1", start_pulses - base); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] ma, na, ra, r2a, resa, mb, nb, rb, r2b, resb, res;
        logic [NW-1:0] lasts;
        bit ok;
        int c0;
        ma   = build_op(32'h0123_4567, 32'h9E37_79B9);
        na   = build_op(32'hF00F_F00F, 32'h0101_0101);
        ra   = build_op(32'h1357_9BDF, 32'h2468_ACE0);
        r2a  = build_op(32'hAAAA_5555, 32'h1111_1111);
        resa = build_op(32'h8765_4321, 32'h7F4A_7C15);
        mb   = ~ma;
        nb   = na ^ ra;
        rb   = build_op(32'h0000_FFFF, 32'h0001_0000);
        r2b  = build_op(32'hCAFE_BABE, 32'h0000_0010);
        resb = build_op(32'h3141_5926, 32'h2718_2818);
        stub_delay  = 3;
        stub_hold   = 2;
        stub_result = resa;
        load_job(ma, na, ra, r2a, 32'h1234_B5DF, 0, ok);
        @(negedge clk);
        n_checks++; if ({eng_msg, eng_n, eng_rmodn, eng_r2modn} !== {ma, na, ra, r2a}) $display("FAIL b2b_operands_a: msg %h want %h", eng_msg, ma); else n_pass++;
        recv_job(res, lasts, ok);
        n_checks++; if (!ok || res !== resa) $display("FAIL b2b_result_a: got %h want %h", res, resa); else n_pass++;
        stub_result = resb;
        c0 = cyc;
        load_job(mb, nb, rb, r2b, 32'h0000_00FF, 0, ok);
        @(negedge clk);
        n_checks++; if (eng_start !== 1'b1 || cyc - c0 != NW * 4 + 1) $display("FAIL b2b_no_lost_cycle: start %b after %0d cycles want 1 after %0d", eng_start, cyc - c0, NW * 4 + 1); else n_pass++;
        n_checks++; if ({eng_msg, eng_n, eng_rmodn, eng_r2modn} !== {mb, nb, rb, r2b}) $display("FAIL b2b_operands_b: msg %h want %h", eng_msg, mb); else n_pass++;
        n_checks++; if (eng_exp !== 16'h00FF) $display("FAIL b2b_exp_b: got %h want 00ff", eng_exp); else n_pass++;
        recv_job(res, lasts, ok);
        n_checks++; if (!ok || res !== resb) $display("FAIL b2b_result_b: got %h want %h", res, resb); else n_pass++;
        n_checks++; if (lasts !== {1'b1, {(NW-1){1'b0}}}) $display("FAIL b2b_last_b: got %h want 80000000", lasts); else n_pass++;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_load();
        test_unload();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
